// File: rtl/cpu6_bus_responder.sv
// ============================================================================
// Module  : cpu6_bus_responder
// Brief   : CPU6 bus target with main RAM and a memory-mapped 8N1 console TX.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu6_bus_responder #(
    parameter int          RAM_ADDR_BITS = 15,
    parameter logic [15:0] MUX_BASE      = 16'hF200,
    parameter int          CLKS_PER_BIT  = 16,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  write_data,
    output logic [7:0]  read_data,
    output logic        tx_serial,
    output logic        tx_active
);

    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_TMR_W     = $clog2(CLKS_PER_BIT);
    localparam int c_RAM_WORDS = 1 << RAM_ADDR_BITS;

    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [15:0]        c_DATA_ADDR = MUX_BASE + 16'd1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [7:0]               r_ram [c_RAM_WORDS];
    logic [7:0]               r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_CNT_W-1:0]       r_count;
    logic                     r_overrun;
    logic [1:0]               r_state;
    logic [c_TMR_W-1:0]       r_timer;
    logic [2:0]               r_bit_idx;
    logic [7:0]               r_shift;

    logic                     w_is_ram;
    logic [RAM_ADDR_BITS-1:0] w_ram_idx;
    logic                     w_push_req;
    logic                     w_push_ok;
    logic                     w_status_wr;
    logic                     w_pop;
    logic                     w_timer_end;
    logic                     w_fifo_full;
    logic                     w_tx_idle;
    logic [7:0]               w_status;
    logic [7:0]               w_rd_next;

    // ---------------- address decode ----------------
    assign w_is_ram    = (address >> RAM_ADDR_BITS) == 16'd0;
    assign w_ram_idx   = address[RAM_ADDR_BITS-1:0];
    assign w_push_req  = write_en && (address == c_DATA_ADDR);
    assign w_status_wr = write_en && (address == MUX_BASE);

    assign w_timer_end = (r_timer == c_TMR_LAST);
    // The serializer takes a byte either from IDLE or straight out of STOP
    assign w_pop       = (r_count != '0) &&
                         ((r_state == c_IDLE) || ((r_state == c_STOP) && w_timer_end));
    assign w_push_ok   = w_push_req && ((r_count < c_DEPTH) || w_pop);

    assign w_fifo_full = (r_count == c_DEPTH);
    assign w_tx_idle   = (r_count == '0) && (r_state == c_IDLE);
    assign w_status    = {3'b000, r_overrun, w_tx_idle, 1'b0, ~w_fifo_full, 1'b0};
    assign tx_active   = (r_state != c_IDLE);

    // ---------------- RAM and read path ----------------
    always_ff @(posedge clock) begin
        if (write_en && w_is_ram) begin
            r_ram[w_ram_idx] <= write_data;
        end
    end

    always_comb begin
        w_rd_next = 8'hFF;
        if (w_is_ram) begin
            w_rd_next = r_ram[w_ram_idx];
        end else if (address == MUX_BASE) begin
            w_rd_next = w_status;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data <= 8'h00;
        end else begin
            read_data <= w_rd_next;
        end
    end

    // ---------------- TX FIFO ----------------
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_fifo_mem[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push_ok) begin
                r_overrun <= 1'b1;
            end else if (w_status_wr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // ---------------- 8N1 serializer ----------------
    // tx_serial is loaded with the level of the state being entered so it is glitch-free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            tx_serial <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_timer <= '0;
                    if (w_pop) begin
                        r_state   <= c_START;
                        r_shift   <= r_fifo_mem[r_rd_ptr];
                        tx_serial <= 1'b0;
                    end
                end
                c_START: begin
                    if (w_timer_end) begin
                        r_state   <= c_DATA;
                        r_timer   <= '0;
                        r_bit_idx <= 3'd0;
                        tx_serial <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_timer_end) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= c_STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            tx_serial <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_STOP: begin
                    if (w_timer_end) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_state   <= c_START;
                            r_shift   <= r_fifo_mem[r_rd_ptr];
                            tx_serial <= 1'b0;
                        end else begin
                            r_state   <= c_IDLE;
                            tx_serial <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_timer   <= '0;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu6_bus_responder.sv
// ============================================================================
// Module  : tb_cpu6_bus_responder
// Brief   : Self-checking bench: directed bus traffic, line-level TX model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu6_bus_responder;

    localparam int          RAM_ADDR_BITS = 15;
    localparam logic [15:0] MUX_BASE      = 16'hF200;
    localparam int          CLKS_PER_BIT  = 16;
    localparam int          FIFO_DEPTH    = 4;
    localparam logic [15:0] c_STAT        = MUX_BASE;
    localparam logic [15:0] c_DATA        = MUX_BASE + 16'd1;
    localparam logic [15:0] c_UNMAP       = 16'h8000;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        tx_serial;
    logic        tx_active;

    int n_checks = 0;
    int n_errors = 0;

    cpu6_bus_responder #(
        .RAM_ADDR_BITS(RAM_ADDR_BITS),
        .MUX_BASE     (MUX_BASE),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .write_en  (write_en),
        .write_data(write_data),
        .read_data (read_data),
        .tx_serial (tx_serial),
        .tx_active (tx_active)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The line is modelled as a queue of per-clock levels; a byte is turned
    // into its 10*CLKS_PER_BIT samples when the line becomes free.
    logic [7:0] m_fifo[$];
    bit         m_line[$];
    bit         m_tx  = 1'b1;
    bit         m_act = 1'b0;
    bit         m_ovr = 1'b0;
    logic [7:0] m_rd  = 8'h00;
    bit         m_rd_valid = 1'b1;
    logic [7:0] m_ram[int];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            m_line.delete();
            m_tx = 1'b1;
            m_act = 1'b0;
            m_ovr = 1'b0;
            m_rd = 8'h00;
            m_rd_valid = 1'b1;
        end else begin
            int  pre_cnt;
            bit  pre_idle;
            bit  pop;
            logic [7:0] b;
            pre_cnt  = m_fifo.size();
            pre_idle = (pre_cnt == 0) && !m_act;
            if (int'(address) < (1 << RAM_ADDR_BITS)) begin
                m_rd_valid = m_ram.exists(int'(address));
                m_rd = m_rd_valid ? m_ram[int'(address)] : 8'h00;
            end else if (address == c_STAT) begin
                m_rd_valid = 1'b1;
                m_rd = {3'b000, m_ovr, pre_idle, 1'b0, (pre_cnt != FIFO_DEPTH), 1'b0};
            end else begin
                m_rd_valid = 1'b1;
                m_rd = 8'hFF;
            end
            pop = (m_line.size() == 0) && (pre_cnt > 0);
            if (pop) begin
                b = m_fifo.pop_front();
                for (int s = 0; s < CLKS_PER_BIT; s++) m_line.push_back(1'b0);
                for (int k = 0; k < 8; k++)
                    for (int s = 0; s < CLKS_PER_BIT; s++) m_line.push_back(b[k]);
                for (int s = 0; s < CLKS_PER_BIT; s++) m_line.push_back(1'b1);
            end
            if (m_line.size() > 0) begin
                m_tx  = m_line.pop_front();
                m_act = 1'b1;
            end else begin
                m_tx  = 1'b1;
                m_act = 1'b0;
            end
            if (write_en) begin
                if (int'(address) < (1 << RAM_ADDR_BITS)) begin
                    m_ram[int'(address)] = write_data;
                end else if (address == c_STAT) begin
                    m_ovr = 1'b0;
                end else if (address == c_DATA) begin
                    if (pre_cnt < FIFO_DEPTH || pop) m_fifo.push_back(write_data);
                    else m_ovr = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the clock edge
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            if (m_rd_valid) check("model read_data", 32'(read_data), 32'(m_rd));
            check("model tx_serial", 32'(tx_serial), 32'(m_tx));
            check("model tx_active", 32'(tx_active), 32'(m_act));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [15:0] a, input logic we, input logic [7:0] d);
        @(negedge clock);
        address    = a;
        write_en   = we;
        write_data = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [9:0] exp_bits;
        bit         samples[200];
        int         act_cnt;
        int         rises;
        bit         prev;
        bit         found;

        reset = 1'b1;
        address = c_UNMAP;
        write_en = 1'b0;
        write_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset read_data", 32'(read_data), 32'h00);
        check("reset tx_serial", 32'(tx_serial), 32'h1);
        check("reset tx_active", 32'(tx_active), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // RAM write/readback and decode boundaries
        step(16'h1234, 1'b1, 8'h5A);
        step(16'h1234, 1'b0, 8'h00);
        check("ram 0x1234", 32'(read_data), 32'h5A);
        step(16'h7FFF, 1'b1, 8'hC3);
        step(16'h0000, 1'b1, 8'h11);
        step(16'h7FFF, 1'b0, 8'h00);
        check("ram 0x7FFF", 32'(read_data), 32'hC3);
        step(16'h0000, 1'b0, 8'h00);
        check("ram 0x0000", 32'(read_data), 32'h11);
        step(c_UNMAP, 1'b1, 8'h77);
        step(c_UNMAP, 1'b0, 8'h00);
        check("unmapped 0x8000", 32'(read_data), 32'hFF);
        step(c_DATA, 1'b0, 8'h00);
        check("data reg read", 32'(read_data), 32'hFF);

        // Idle status
        step(c_STAT, 1'b0, 8'h00);
        check("idle status", 32'(read_data), 32'h0A);
        check("idle tx_serial", 32'(tx_serial), 32'h1);

        // Single byte 0x41
        step(c_DATA, 1'b1, 8'h41);
        step(c_STAT, 1'b0, 8'h00);
        check("status in frame", 32'(read_data), 32'h02);
        act_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            samples[i] = tx_serial;
            if (tx_active) act_cnt++;
            step(c_STAT, 1'b0, 8'h00);
        end
        exp_bits = 10'b1010000010;
        for (int k = 0; k < 10; k++)
            check($sformatf("0x41 bit %0d", k), 32'(samples[k*CLKS_PER_BIT + 8]), 32'(exp_bits[k]));
        check("0x41 active clocks", 32'(act_cnt), 32'd160);
        check("status after frame", 32'(read_data), 32'h0A);

        // Overflow: six back-to-back pushes
        for (int i = 0; i < 6; i++) step(c_DATA, 1'b1, 8'(8'h10 + i));
        step(c_STAT, 1'b0, 8'h00);
        check("overflow status", 32'(read_data), 32'h10);
        step(c_STAT, 1'b1, 8'h00);
        step(c_STAT, 1'b0, 8'h00);
        check("overrun cleared", 32'(read_data), 32'h00);
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            step(c_STAT, 1'b0, 8'h00);
            if (read_data == 8'h0A) found = 1'b1;
        end
        check("overflow drain", 32'(found), 32'h1);

        // Back-to-back frames
        step(c_DATA, 1'b1, 8'h55);
        step(c_DATA, 1'b1, 8'hAA);
        act_cnt = 0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (tx_active) act_cnt++;
            if (tx_active && !prev) rises++;
            prev = tx_active;
            step(c_STAT, 1'b0, 8'h00);
        end
        check("b2b active clocks", 32'(act_cnt), 32'd320);
        check("b2b single burst", 32'(rises), 32'd1);

        // Reset during DATA bit 3 with a second byte queued
        step(c_DATA, 1'b1, 8'hC3);
        step(c_DATA, 1'b1, 8'h99);
        for (int i = 0; i < 70; i++) step(c_STAT, 1'b0, 8'h00);
        check("mid-frame active", 32'(tx_active), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset tx_serial", 32'(tx_serial), 32'h1);
        check("async reset tx_active", 32'(tx_active), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        step(c_STAT, 1'b0, 8'h00);
        check("status after reset", 32'(read_data), 32'h0A);
        act_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (tx_active) act_cnt++;
            step(c_STAT, 1'b0, 8'h00);
        end
        check("no frames after reset", 32'(act_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
